// File: rtl/alu_pkg.sv
// Shared types and widths for the 8-bit signed ALU.
package alu_pkg;

    localparam int ALU_W    = 8;
    localparam int ALU_OP_W = 3;

    // Opcode encodings; 3'b101..3'b111 are reserved and produce zero.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_EQ  = 3'b011,
        ALU_GT  = 3'b100
    } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU function: result = f(op, a, b), all operands signed.
module alu_core
    import alu_pkg::*;
(
    input  logic        [ALU_OP_W-1:0] op_in,
    input  logic signed [ALU_W-1:0]    a_in,
    input  logic signed [ALU_W-1:0]    b_in,
    output logic signed [ALU_W-1:0]    result_out
);

    // Operands sign-extended to the full product width so the multiply is signed.
    logic signed [2*ALU_W-1:0] a_ext;
    logic signed [2*ALU_W-1:0] b_ext;
    logic signed [2*ALU_W-1:0] prod;

    // Sign extension and the full 16-bit signed product.
    always_comb begin
        a_ext = (2*ALU_W)'(a_in);
        b_ext = (2*ALU_W)'(b_in);
        prod  = a_ext * b_ext;
    end

    // Operation select; arithmetic wraps to 8 bits, compares yield 0/1.
    always_comb begin
        result_out = '0;
        case (op_in)
            ALU_ADD: result_out = a_in + b_in;
            ALU_SUB: result_out = a_in - b_in;
            ALU_MUL: result_out = prod[ALU_W-1:0];
            ALU_EQ:  result_out = {{(ALU_W-1){1'b0}}, (a_in == b_in)};
            ALU_GT:  result_out = {{(ALU_W-1){1'b0}}, (a_in > b_in)};
            default: result_out = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// 8-bit signed ALU with a single registered result (1-cycle latency, enable-gated).
module alu
    import alu_pkg::*;
(
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic                    enable_in,
    input  logic        [2:0]       opcode_in,
    input  logic signed [ALU_W-1:0] alu_input1,
    input  logic signed [ALU_W-1:0] alu_input2,
    output logic signed [ALU_W-1:0] alu_output
);

    logic signed [ALU_W-1:0] core_result;
    logic signed [ALU_W-1:0] alu_output_d;
    logic signed [ALU_W-1:0] alu_output_q;

    alu_core u_alu_core (
        .op_in      (opcode_in),
        .a_in       (alu_input1),
        .b_in       (alu_input2),
        .result_out (core_result)
    );

    // Next result: capture the core output when enabled, otherwise hold.
    always_comb begin
        alu_output_d = alu_output_q;
        if (enable_in) begin
            alu_output_d = core_result;
        end
    end

    // Output register; reset clears the result and overrides enable.
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            alu_output_q <= '0;
        end else begin
            alu_output_q <= alu_output_d;
        end
    end

    assign alu_output = alu_output_q;

endmodule

// File: tb/tb_alu.sv
// Directed and swept checks of the registered 8-bit signed ALU.
module tb_alu;

    logic              clock_in;
    logic              reset_in;
    logic              enable_in;
    logic        [2:0] opcode_in;
    logic signed [7:0] alu_input1;
    logic signed [7:0] alu_input2;
    logic signed [7:0] alu_output;

    int n_checks;
    int n_pass;

    alu dut (
        .clock_in   (clock_in),
        .reset_in   (reset_in),
        .enable_in  (enable_in),
        .opcode_in  (opcode_in),
        .alu_input1 (alu_input1),
        .alu_input2 (alu_input2),
        .alu_output (alu_output)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Count one comparison and report it if the observed value differs.
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, got, exp);
        end
    endtask

    // Drive one operation, clock it in, then sample just after the edge.
    task automatic step(input logic rst_n, input logic en, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b);
        reset_in   = rst_n;
        enable_in  = en;
        opcode_in  = op;
        alu_input1 = a;
        alu_input2 = b;
        @(posedge clock_in);
        #1;
    endtask

    // Independent reference using 32-bit integer arithmetic truncated to 8 bits.
    function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        int sa;
        int sb;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            3'd0:    r = sa + sb;
            3'd1:    r = sa - sb;
            3'd2:    r = sa * sb;
            3'd3:    r = (sa == sb) ? 1 : 0;
            3'd4:    r = (sa > sb) ? 1 : 0;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    // Directed vector: op, A, B, hand-computed result.
    typedef struct {
        string      tag;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [7:0] b;
        n_checks = 0;
        n_pass   = 0;

        vecs.push_back('{"add 127+1",    3'b000, 8'd127, 8'd1,   8'h80});
        vecs.push_back('{"add -128+-1",  3'b000, 8'h80,  8'hFF,  8'h7F});
        vecs.push_back('{"sub -128-1",   3'b001, 8'h80,  8'd1,   8'h7F});
        vecs.push_back('{"sub 5-7",      3'b001, 8'd5,   8'd7,   8'hFE});
        vecs.push_back('{"mul -3*5",     3'b010, 8'hFD,  8'd5,   8'hF1});
        vecs.push_back('{"mul 16*16",    3'b010, 8'd16,  8'd16,  8'h00});
        vecs.push_back('{"mul -128*-1",  3'b010, 8'h80,  8'hFF,  8'h80});
        vecs.push_back('{"mul -1*-1",    3'b010, 8'hFF,  8'hFF,  8'h01});
        vecs.push_back('{"eq 5,5",       3'b011, 8'd5,   8'd5,   8'h01});
        vecs.push_back('{"eq 5,-5",      3'b011, 8'd5,   8'hFB,  8'h00});
        vecs.push_back('{"gt -1,-128",   3'b100, 8'hFF,  8'h80,  8'h01});
        vecs.push_back('{"gt -128,1",    3'b100, 8'h80,  8'd1,   8'h00});
        vecs.push_back('{"gt 7,7",       3'b100, 8'd7,   8'd7,   8'h00});
        vecs.push_back('{"gt 1,-1",      3'b100, 8'd1,   8'hFF,  8'h01});

        // Reset with a live ADD on the inputs: result discarded, output 0.
        step(1'b0, 1'b1, 3'b000, 8'd3, 8'd4);
        check("reset", alu_output, 8'h00);
        step(1'b1, 1'b1, 3'b000, 8'd3, 8'd4);
        check("add 3+4 after reset", alu_output, 8'h07);

        foreach (vecs[i]) begin
            step(1'b1, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            check(vecs[i].tag, alu_output, vecs[i].exp);
        end

        // Enable hold and reserved opcode.
        step(1'b1, 1'b1, 3'b001, 8'd10, 8'd3);
        check("sub 10-3", alu_output, 8'h07);
        step(1'b1, 1'b0, 3'b000, 8'd1, 8'd1);
        check("hold en=0", alu_output, 8'h07);
        step(1'b1, 1'b0, 3'b010, 8'd9, 8'd9);
        check("hold en=0 again", alu_output, 8'h07);
        step(1'b1, 1'b1, 3'b110, 8'd12, 8'd34);
        check("reserved 110", alu_output, 8'h00);

        // Mid-stream reset takes priority over enable, even with enable low.
        step(1'b1, 1'b1, 3'b000, 8'd20, 8'd22);
        check("add 20+22", alu_output, 8'h2A);
        step(1'b0, 1'b0, 3'b000, 8'd1, 8'd1);
        check("reset with en=0", alu_output, 8'h00);

        // Sweep: all opcodes, every A, 32 B values spread across the range.
        for (int op = 0; op < 8; op++) begin
            for (int a = 0; a < 256; a++) begin
                for (int j = 0; j < 32; j++) begin
                    b = 8'((j * 8) + (j % 8));
                    step(1'b1, 1'b1, 3'(op), 8'(a), b);
                    check($sformatf("sweep op=%0d a=%0d b=%0d", op, a, b),
                          alu_output, ref_alu(3'(op), 8'(a), b));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
